// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared channel state type and channel indices for the memory port controller
package mem_ctrl_pkg;

    typedef enum logic {CH_IDLE, CH_ISSUE} ch_state_t;

    localparam int CH_IMEM = 0;
    localparam int CH_DMEM = 1;

endpackage

// File: rtl/resp_fifo.sv
// resp_fifo: synchronous response FIFO, pointers wrap modulo DEPTH so any depth works
module resp_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CAP = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             wr, rd;

    assign wr    = push && !full;
    assign rd    = pop && !empty;
    assign full  = count == CAP;
    assign empty = count == '0;
    assign head  = mem[rd_ptr];

    // storage, wrapping pointers and occupancy; cleared so head reads 0 out of reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
            end
            if (rd) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(wr) - CW'(rd);
        end
    end

endmodule

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: independent per-channel request/response controllers between core and memories
module mem_port_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int NBITS     = 32,
    parameter int NCH       = 2,
    parameter int MAX_OUTST = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NCH-1:0]            core_req,
    input  logic [NCH-1:0][NBITS-1:0] core_addr,
    input  logic [NCH-1:0][NBITS-1:0] core_wdata,
    input  logic [NCH-1:0]            core_wen,
    output logic [NCH-1:0]            core_gnt,
    output logic [NCH-1:0]            stall,
    output logic                      mem_stall,
    output logic [NCH-1:0]            resp_valid,
    output logic [NCH-1:0][NBITS-1:0] resp_data,
    input  logic [NCH-1:0]            resp_pop,
    output logic [NCH-1:0]            proc_req,
    output logic [NCH-1:0][NBITS-1:0] mem_addr,
    output logic [NCH-1:0][NBITS-1:0] mem_wdata,
    output logic [NCH-1:0]            mem_wen,
    input  logic [NCH-1:0]            mem_rdy,
    input  logic [NCH-1:0]            mem_valid,
    input  logic [NCH-1:0][NBITS-1:0] mem_data,
    output logic [NCH-1:0]            err
);

    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam logic [CW-1:0] MAXC = CW'(MAX_OUTST);

    assign mem_stall = |stall;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        ch_state_t        state, state_nx;
        logic [CW-1:0]    outst, inflight;
        logic [NBITS-1:0] addr_q, wdata_q;
        logic             wen_q, err_q;
        logic             gnt, xfer, pop, acc, full, empty;

        // grant only when the request slot frees this cycle and the response budget allows;
        // reset forces the grant low so every output reads 0 while rst=0
        always_comb begin
            xfer     = state == CH_ISSUE && mem_rdy[c];
            gnt      = rst && core_req[c] && (state == CH_IDLE || mem_rdy[c]) && outst < MAXC;
            pop      = resp_pop[c] && !empty;
            acc      = mem_valid[c] && inflight != '0 && !full;
            state_nx = gnt ? CH_ISSUE : xfer ? CH_IDLE : state;
        end

        // channel state register
        always_ff @(posedge clk) begin
            if (!rst) state <= CH_IDLE;
            else      state <= state_nx;
        end

        // request register, outstanding/in-flight counters and sticky error
        always_ff @(posedge clk) begin
            if (!rst) begin
                addr_q   <= '0;
                wdata_q  <= '0;
                wen_q    <= 1'b0;
                outst    <= '0;
                inflight <= '0;
                err_q    <= 1'b0;
            end else begin
                if (gnt) begin
                    addr_q  <= core_addr[c];
                    wdata_q <= core_wdata[c];
                    wen_q   <= core_wen[c];
                end
                outst    <= outst + CW'(gnt) - CW'(pop);
                inflight <= inflight + CW'(xfer) - CW'(acc);
                if (mem_valid[c] && !acc) err_q <= 1'b1;
            end
        end

        resp_fifo #(.WIDTH(NBITS), .DEPTH(MAX_OUTST)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (acc),
            .pop   (pop),
            .din   (mem_data[c]),
            .head  (resp_data[c]),
            .full  (full),
            .empty (empty)
        );

        assign core_gnt[c]   = gnt;
        assign stall[c]      = rst && core_req[c] && !gnt;
        assign resp_valid[c] = !empty;
        assign proc_req[c]   = state == CH_ISSUE;
        assign mem_addr[c]   = addr_q;
        assign mem_wdata[c]  = wdata_q;
        assign mem_wen[c]    = wen_q;
        assign err[c]        = err_q;
    end

endmodule
